// File: rtl/fifo_tx_drain.sv
// Read-side drain of the transceiver async FIFO: pops one word at a time from the
// first-word-fall-through port and feeds its bytes to the UART transmitter.
module fifo_tx_drain #(
  parameter int Data_Width = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  input  logic [Data_Width-1:0] r_data,
  output logic                  r_inc,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  drain_busy
);
  localparam int BYTES = Data_Width / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP       = 2'd1,
    REQ       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [Data_Width-1:0]   word_q, word_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    r_inc_q, r_inc_d;
  logic [CNT_W-1:0]        next_cnt;

  // Byte index counts transmission order; MSB_FIRST mirrors it onto the word.
  function automatic logic [7:0] pick_byte(input logic [Data_Width-1:0] word,
                                           input logic [CNT_W-1:0]      idx);
    logic [CNT_W-1:0] pos;
    pos = MSB_FIRST ? (LAST_IDX - idx) : idx;
    return word[8*pos +: 8];
  endfunction

  assign next_cnt = byte_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    r_inc_d    = r_inc_q;
    unique case (state_q)
      IDLE: begin
        if (en && !empty) begin
          word_d     = r_data;
          r_inc_d    = 1'b1;
          byte_cnt_d = '0;
          state_d    = POP;
        end
      end
      POP: begin
        r_inc_d    = 1'b0;
        tx_data_d  = pick_byte(word_q, byte_cnt_q);
        tx_valid_d = 1'b1;
        state_d    = REQ;
      end
      REQ: begin
        if (tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // en is deliberately not consulted here: a started word always completes.
        if (!tx_busy) begin
          if (byte_cnt_q < LAST_IDX) begin
            byte_cnt_d = next_cnt;
            tx_data_d  = pick_byte(word_q, next_cnt);
            tx_valid_d = 1'b1;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      r_inc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      r_inc_q    <= r_inc_d;
    end
  end

  assign r_inc      = r_inc_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign drain_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Bench for fifo_tx_drain: a 16-bit LSB-first and a 32-bit MSB-first instance, each
// fed by a queue FIFO model and a UART busy model, with a byte scoreboard per instance.
`timescale 1ns/1ps
module tb_fifo_tx_drain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en         [2];
  logic        empty      [2];
  logic [31:0] rdata      [2];
  logic        r_inc      [2];
  logic [7:0]  tx_data    [2];
  logic        tx_valid   [2];
  logic        tx_busy    [2];
  logic        drain_busy [2];

  fifo_tx_drain #(.Data_Width(16), .MSB_FIRST(1'b0)) u_lsb16 (
    .clk(clk), .rst(rst), .en(en[0]), .empty(empty[0]), .r_data(rdata[0][15:0]),
    .r_inc(r_inc[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_busy(tx_busy[0]), .drain_busy(drain_busy[0]));

  fifo_tx_drain #(.Data_Width(32), .MSB_FIRST(1'b1)) u_msb32 (
    .clk(clk), .rst(rst), .en(en[1]), .empty(empty[1]), .r_data(rdata[1]),
    .r_inc(r_inc[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_busy(tx_busy[1]), .drain_busy(drain_busy[1]));

  int          nbytes [2] = '{2, 4};
  bit          msb    [2] = '{1'b0, 1'b1};
  logic [31:0] wmask  [2] = '{32'h0000FFFF, 32'hFFFFFFFF};

  logic [31:0] fifo  [2][$];
  logic [7:0]  exp_q [2][$];
  int          bytes_left [2];
  int          bcnt       [2];
  int          hold_cnt   [2];
  int          pops       [2] = '{0, 0};
  int          accepts    [2] = '{0, 0};
  logic        prev_valid [2];
  logic [7:0]  held       [2];
  int          busy_len = 10;
  bit          rand_mode = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transmission order i of word w: byte i from the bottom, or from the top if MSB-first.
  function automatic logic [7:0] ref_byte(input logic [31:0] w, input int k, input int i);
    int pos;
    pos = msb[k] ? (nbytes[k] - 1 - i) : i;
    return 8'((w >> (8 * pos)) & 32'hFF);
  endfunction

  function automatic void upd(input int k);
    empty[k] = (fifo[k].size() == 0);
    rdata[k] = empty[k] ? 32'h0 : fifo[k][0];
  endfunction

  // FIFO read side, UART busy model and scoreboard, evaluated 1ns after each edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_q[k].delete();
        bytes_left[k] = 0;
        tx_busy[k]    = 1'b0;
        bcnt[k]       = 0;
        hold_cnt[k]   = 0;
        prev_valid[k] = 1'b0;
      end else begin
        if (r_inc[k]) begin
          pops[k]++;
          chk("pop_inside_open_word", bytes_left[k], 0);
          chk("fifo_nonempty_at_pop", 32'(fifo[k].size() != 0), 1);
          if (fifo[k].size() != 0) begin
            logic [31:0] w;
            w = fifo[k].pop_front();
            for (int i = 0; i < nbytes[k]; i++) exp_q[k].push_back(ref_byte(w, k, i));
          end
          bytes_left[k] = nbytes[k];
        end
        if (tx_valid[k] && !prev_valid[k]) begin
          chk("busy_low_on_req", tx_busy[k], 0);
          held[k]     = tx_data[k];
          hold_cnt[k] = rand_mode ? int'($urandom_range(0, 2)) : 0;
        end else if (tx_valid[k]) begin
          chk("tx_data_stable", tx_data[k], held[k]);
        end
        if (tx_busy[k]) begin
          if (bcnt[k] <= 1) tx_busy[k] = 1'b0;
          else bcnt[k]--;
        end else if (tx_valid[k]) begin
          if (hold_cnt[k] > 0) hold_cnt[k]--;
          else begin
            accepts[k]++;
            chk("exp_byte_available", 32'(exp_q[k].size() != 0), 1);
            if (exp_q[k].size() != 0) chk("tx_byte", tx_data[k], exp_q[k].pop_front());
            bytes_left[k]--;
            tx_busy[k] = 1'b1;
            bcnt[k]    = rand_mode ? int'($urandom_range(1, 6)) : busy_len;
          end
        end
        prev_valid[k] = tx_valid[k];
      end
      upd(k);
    end
  end

  task automatic wait_idle(input int k, input string name);
    int n;
    n = 0;
    while (n < 3000 && !(fifo[k].size() == 0 && !drain_busy[k] && !tx_busy[k] &&
                         exp_q[k].size() == 0)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n >= 3000), 0);
    chk({name, "_drain_busy_end"}, drain_busy[k], 0);
    chk({name, "_bytes_left"}, exp_q[k].size(), 0);
  endtask

  task automatic wait_accepts(input int k, input int target, input string name);
    int n;
    n = 0;
    while (n < 500 && accepts[k] < target) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept_timeout"}, 32'(n >= 500), 0);
  endtask

  initial begin
    int p, a;
    rst = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b0;
    fifo[0].push_back(32'h1234);

    // Reset: outputs held low with a non-empty FIFO, then 1-cycle pop, 2-cycle valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_r_inc", r_inc[0], 0);
      chk("rst_tx_valid", tx_valid[0], 0);
      chk("rst_tx_data", tx_data[0], 0);
      chk("rst_drain_busy", drain_busy[0], 0);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    chk("lat_r_inc_edge1", r_inc[0], 1);
    chk("lat_tx_valid_edge1", tx_valid[0], 0);
    chk("lat_drain_busy_edge1", drain_busy[0], 1);
    @(posedge clk); #2;
    chk("lat_tx_valid_edge2", tx_valid[0], 1);
    chk("lat_r_inc_edge2", r_inc[0], 0);
    chk("lat_tx_data_edge2", tx_data[0], 8'h34);
    wait_idle(0, "reset_word");

    // Single 16-bit word, LSB first, busy held 10 cycles per byte.
    @(negedge clk);
    p = pops[0]; a = accepts[0];
    fifo[0].push_back(32'hA55A);
    wait_idle(0, "single");
    chk("single_pops", pops[0] - p, 1);
    chk("single_accepts", accepts[0] - a, 2);

    // 32-bit MSB-first word.
    @(negedge clk);
    p = pops[1]; a = accepts[1];
    en[1] = 1'b1;
    fifo[1].push_back(32'h11223344);
    wait_idle(1, "msb32");
    chk("msb32_pops", pops[1] - p, 1);
    chk("msb32_accepts", accepts[1] - a, 4);

    // Three words back to back.
    @(negedge clk);
    p = pops[0]; a = accepts[0];
    fifo[0].push_back(32'h0102);
    fifo[0].push_back(32'h0304);
    fifo[0].push_back(32'h0506);
    wait_idle(0, "b2b");
    chk("b2b_pops", pops[0] - p, 3);
    chk("b2b_accepts", accepts[0] - a, 6);

    // Enable dropped after the first byte: word completes, no further pop.
    @(negedge clk);
    p = pops[0]; a = accepts[0];
    fifo[0].push_back(32'hBEEF);
    fifo[0].push_back(32'h1357);
    wait_accepts(0, a + 1, "engate");
    en[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 500 && (drain_busy[0] || exp_q[0].size() != 0)) begin
        @(negedge clk);
        n++;
      end
      chk("engate_finish_timeout", 32'(n >= 500), 0);
    end
    repeat (20) @(negedge clk);
    chk("engate_pops_while_off", pops[0] - p, 1);
    chk("engate_accepts", accepts[0] - a, 2);
    chk("engate_fifo_left", fifo[0].size(), 1);
    en[0] = 1'b1;
    @(posedge clk); #2;
    chk("engate_resume_pop", r_inc[0], 1);
    wait_idle(0, "engate");

    // Reset while waiting on busy after byte 0; the partial word is dropped.
    @(negedge clk);
    a = accepts[0];
    fifo[0].push_back(32'hC3D2);
    fifo[0].push_back(32'h7E81);
    wait_accepts(0, a + 1, "midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", tx_valid[0], 0);
    chk("midrst_r_inc", r_inc[0], 0);
    chk("midrst_drain_busy", drain_busy[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p = pops[0]; a = accepts[0];
    wait_idle(0, "midrst");
    chk("midrst_pops_after", pops[0] - p, 1);
    chk("midrst_accepts_after", accepts[0] - a, 2);

    // Randomised traffic on both instances with en toggling and variable busy timing.
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 9) == 0 && fifo[k].size() < 8)
          fifo[k].push_back($urandom & wmask[k]);
        if ($urandom_range(0, 19) == 0) en[k] = 1'($urandom_range(0, 1));
      end
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    wait_idle(0, "rand_lsb16");
    wait_idle(1, "rand_msb32");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
